// File: rtl/id_stage_param.sv
// id_stage_param -- MIPS instruction-decode stage with ID/EX pipeline register.
//
// Holds the register file (two combinational read ports with write-through
// bypass), the Rs/Rt forwarding muxes, the branch comparator, the
// branch-target adder and the ID/EX register (valid bit, stall hold, flush
// bubble).
//
// Optional feature macro: ID_ZEXT_LOGIC_EN
//   defined   : andi/ori/xori (opcode 0x0C/0x0D/0x0E) zero-extend the
//               immediate fed to SignImmE; the branch target keeps using
//               the sign-extended immediate.
//   undefined : the immediate is always sign-extended.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   InstrD, PCPlus4D       instruction in ID and its PC+4
//   ResultW/WriteRegW/RegWriteW  writeback data, index, enable
//   ALUOutM                MEM-stage result for forwarding
//   ForwardAD/ForwardBD    operand select: 01 ALUOutM, 10 ResultW, else regfile
//   StallE, FlushE         ID/EX hold and bubble controls
//   RsD, RtD               decoded source indices
//   EqualD, PCBranchD      branch compare and branch target
//   A, B, SignImmE, Op, Funct, RsE, RtE, RdE, ValidE   ID/EX register outputs

module id_stage_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       InstrD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic              RegWriteW,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [1:0]        ForwardAD,
  input  logic [1:0]        ForwardBD,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [ADDR_W-1:0] RsD,
  output logic [ADDR_W-1:0] RtD,
  output logic              EqualD,
  output logic [DATA_W-1:0] PCBranchD,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] SignImmE,
  output logic [5:0]        Op,
  output logic [5:0]        Funct,
  output logic [ADDR_W-1:0] RsE,
  output logic [ADDR_W-1:0] RtE,
  output logic [ADDR_W-1:0] RdE,
  output logic              ValidE
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic [ADDR_W-1:0] w_rs, w_rt, w_rd;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic [DATA_W-1:0] w_fwd1, w_fwd2;
  logic [DATA_W-1:0] w_sext, w_zext, w_signimm;

  // Size casts zero-pad or truncate the 5-bit instruction fields to ADDR_W.
  assign w_rs = ADDR_W'(InstrD[25:21]);
  assign w_rt = ADDR_W'(InstrD[20:16]);
  assign w_rd = ADDR_W'(InstrD[15:11]);
  assign RsD  = w_rs;
  assign RtD  = w_rt;

  assign w_wr_en = RegWriteW && (WriteRegW != '0);

  // Read ports: r0 is hard zero; a same-cycle write to the read index is
  // bypassed so writeback-to-decode needs no extra stall.
  always_comb begin
    w_rd1 = r_regs[w_rs];
    if (w_rs == '0)
      w_rd1 = '0;
    else if (w_wr_en && (WriteRegW == w_rs))
      w_rd1 = ResultW;

    w_rd2 = r_regs[w_rt];
    if (w_rt == '0)
      w_rd2 = '0;
    else if (w_wr_en && (WriteRegW == w_rt))
      w_rd2 = ResultW;
  end

  always_comb begin
    case (ForwardAD)
      2'b01:   w_fwd1 = ALUOutM;
      2'b10:   w_fwd1 = ResultW;
      default: w_fwd1 = w_rd1;
    endcase
    case (ForwardBD)
      2'b01:   w_fwd2 = ALUOutM;
      2'b10:   w_fwd2 = ResultW;
      default: w_fwd2 = w_rd2;
    endcase
  end

  assign EqualD = (w_fwd1 == w_fwd2);

  assign w_sext = DATA_W'($signed(InstrD[IMM_W-1:0]));
  assign w_zext = DATA_W'(InstrD[IMM_W-1:0]);

`ifdef ID_ZEXT_LOGIC_EN
  // Logical immediates are unsigned; only the ALU operand changes.
  assign w_signimm = (InstrD[31:26] inside {6'h0C, 6'h0D, 6'h0E}) ? w_zext : w_sext;
`else
  assign w_signimm = w_sext;
`endif

  // Target is always PC+4 plus the sign-extended word offset; overflow wraps.
  assign PCBranchD = PCPlus4D + (w_sext << 2);

  // Register file write port. Reset wins over a coincident writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[WriteRegW] <= ResultW;
    end
  end

  // ID/EX register: reset, then flush (bubble), then stall (hold), else load.
  always_ff @(posedge clk) begin
    if (!rst_n || FlushE) begin
      A        <= '0;
      B        <= '0;
      SignImmE <= '0;
      Op       <= '0;
      Funct    <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else if (!StallE) begin
      A        <= w_fwd1;
      B        <= w_fwd2;
      SignImmE <= w_signimm;
      Op       <= InstrD[31:26];
      Funct    <= InstrD[5:0];
      RsE      <= w_rs;
      RtE      <= w_rt;
      RdE      <= w_rd;
      ValidE   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_param.sv
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] InstrD, PCPlus4D, ResultW, ALUOutM;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic [1:0]  ForwardAD, ForwardBD;
  logic        StallE, FlushE;
  logic [4:0]  RsD, RtD, RsE, RtE, RdE;
  logic        EqualD, ValidE;
  logic [31:0] PCBranchD, A, B, SignImmE;
  logic [5:0]  Op, Funct;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_param #(.DATA_W(32), .ADDR_W(5), .IMM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ResultW(ResultW), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallE(StallE), .FlushE(FlushE), .RsD(RsD), .RtD(RtD),
    .EqualD(EqualD), .PCBranchD(PCBranchD), .A(A), .B(B),
    .SignImmE(SignImmE), .Op(Op), .Funct(Funct), .RsE(RsE), .RtE(RtE),
    .RdE(RdE), .ValidE(ValidE)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a, b, simm;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } ex_t;

  logic [31:0] m_regs [32];
  ex_t         m_ex;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWriteW && WriteRegW == idx) return ResultW;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] m_opnd(input logic [1:0] sel, input logic [4:0] idx);
    if (sel == 2'b01) return ALUOutM;
    if (sel == 2'b10) return ResultW;
    return m_read(idx);
  endfunction

  function automatic logic [31:0] m_sext();
    int signed v;
    v = int'($signed(InstrD[15:0]));
    return v;
  endfunction

  function automatic logic [31:0] m_imm();
`ifdef ID_ZEXT_LOGIC_EN
    if (InstrD[31:26] >= 6'h0C && InstrD[31:26] <= 6'h0E) return {16'h0, InstrD[15:0]};
`endif
    return m_sext();
  endfunction

  task automatic m_edge();
    ex_t nxt;
    nxt = m_ex;
    if (!rst_n || FlushE) nxt = '0;
    else if (!StallE) begin
      nxt.a = m_opnd(ForwardAD, InstrD[25:21]);
      nxt.b = m_opnd(ForwardBD, InstrD[20:16]);
      nxt.simm = m_imm();
      nxt.op = InstrD[31:26];
      nxt.funct = InstrD[5:0];
      nxt.rs = InstrD[25:21];
      nxt.rt = InstrD[20:16];
      nxt.rd = InstrD[15:11];
      nxt.valid = 1'b1;
    end
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (RegWriteW && WriteRegW != 0) begin
      m_regs[WriteRegW] = ResultW;
    end
    m_ex = nxt;
  endtask

  task automatic check_ex();
    chk("ValidE", {31'h0, ValidE}, {31'h0, m_ex.valid});
    chk("A", A, m_ex.a);
    chk("B", B, m_ex.b);
    chk("SignImmE", SignImmE, m_ex.simm);
    chk("Op", {26'h0, Op}, {26'h0, m_ex.op});
    chk("Funct", {26'h0, Funct}, {26'h0, m_ex.funct});
    chk("RsE", {27'h0, RsE}, {27'h0, m_ex.rs});
    chk("RtE", {27'h0, RtE}, {27'h0, m_ex.rt});
    chk("RdE", {27'h0, RdE}, {27'h0, m_ex.rd});
  endtask

  // Combinational outputs compared at the falling edge.
  task automatic half1();
    logic [31:0] pcb;
    @(negedge clk);
    pcb = PCPlus4D + (m_sext() * 4);
    chk("RsD", {27'h0, RsD}, {27'h0, InstrD[25:21]});
    chk("RtD", {27'h0, RtD}, {27'h0, InstrD[20:16]});
    chk("EqualD", {31'h0, EqualD},
        {31'h0, m_opnd(ForwardAD, InstrD[25:21]) == m_opnd(ForwardBD, InstrD[20:16])});
    chk("PCBranchD", PCBranchD, pcb);
  endtask

  task automatic half2();
    @(posedge clk);
    m_edge();
    #1;
    check_ex();
  endtask

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic [31:0] res, input logic [4:0] wreg, input logic rw,
                       input logic [31:0] alu, input logic [1:0] fa, input logic [1:0] fb,
                       input logic stall, input logic flush);
    InstrD = instr; PCPlus4D = pc4; ResultW = res; WriteRegW = wreg; RegWriteW = rw;
    ALUOutM = alu; ForwardAD = fa; ForwardBD = fb; StallE = stall; FlushE = flush;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] instr, pc4, res;
    logic [4:0]  wreg;
    logic        rw;
    logic [31:0] alu;
    logic [1:0]  fa, fb;
    logic        stall, flush;
    logic        e_eq;
    logic [31:0] e_pcb;
    logic        e_valid;
    logic [31:0] e_a, e_b, e_simm;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] ori_simm;
`ifdef ID_ZEXT_LOGIC_EN
    ori_simm = 32'h0000_8000;
`else
    ori_simm = 32'hFFFF_8000;
`endif
    tbl[0]  = '{ins(6'h08, 0, 0, 16'h0004), 32'h100, 32'h1234, 5'd5, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'h110, 1'b1, 32'h0, 32'h0, 32'h4};
    tbl[1]  = '{ins(6'h08, 5, 0, 16'h0001), 32'h200, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b0, 32'h204, 1'b1, 32'h1234, 32'h0, 32'h1};
    tbl[2]  = '{ins(6'h08, 7, 5, 16'hFFFF), 32'h100, 32'hDEADBEEF, 5'd7, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b0, 32'hFC, 1'b1, 32'hDEADBEEF, 32'h1234, 32'hFFFFFFFF};
    tbl[3]  = '{ins(6'h04, 7, 7, 16'h8000), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'hFFFE0000, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFF8000};
    tbl[4]  = '{ins(6'h04, 0, 0, 16'h0000), 32'h40, 32'hFFFFFFFF, 5'd0, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'h40, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{ins(6'h08, 0, 0, 16'h0002), 32'h40, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'h48, 1'b1, 32'h0, 32'h0, 32'h2};
    tbl[6]  = '{ins(6'h08, 7, 5, 16'h7FFF), 32'hFFFFFFF0, 32'h10, 5'd0, 1'b0, 32'h10, 2'd1, 2'd2, 1'b0, 1'b0,
                1'b1, 32'h0001FFEC, 1'b1, 32'h10, 32'h10, 32'h7FFF};
    tbl[7]  = '{ins(6'h08, 7, 7, 16'h0000), 32'h0, 32'h66, 5'd0, 1'b0, 32'h55, 2'd3, 2'd3, 1'b0, 1'b0,
                1'b1, 32'h0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{ins(6'h08, 5, 7, 16'h0010), 32'h0, 32'h99, 5'd9, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1,
                1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 32'h0};
    tbl[9]  = '{ins(6'h08, 9, 9, 16'h0000), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'h0, 1'b1, 32'h99, 32'h99, 32'h0};
    tbl[10] = '{ins(6'h0D, 0, 0, 16'h8000), 32'h1000, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0,
                1'b1, 32'hFFFE1000, 1'b1, 32'h0, 32'h0, ori_simm};
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ex = '0;
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);

    // reset held two cycles
    repeat (2) begin
      @(posedge clk);
      m_edge();
    end
    #1;
    check_ex();
    chk("rst_ValidE", {31'h0, ValidE}, 32'h0);
    chk("rst_A", A, 32'h0);
    chk("rst_B", B, 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) begin
      drive(ins(6'h08, 5'(i), 5'(i), 16'h0), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
      half1();
      half2();
      chk("rst_rd_A", A, 32'h0);
      chk("rst_rd_B", B, 32'h0);
    end

    // table-driven directed vectors
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].instr, tbl[k].pc4, tbl[k].res, tbl[k].wreg, tbl[k].rw, tbl[k].alu,
            tbl[k].fa, tbl[k].fb, tbl[k].stall, tbl[k].flush);
      half1();
      chk($sformatf("v%0d_EqualD", k), {31'h0, EqualD}, {31'h0, tbl[k].e_eq});
      chk($sformatf("v%0d_PCBranchD", k), PCBranchD, tbl[k].e_pcb);
      half2();
      chk($sformatf("v%0d_ValidE", k), {31'h0, ValidE}, {31'h0, tbl[k].e_valid});
      chk($sformatf("v%0d_A", k), A, tbl[k].e_a);
      chk($sformatf("v%0d_B", k), B, tbl[k].e_b);
      chk($sformatf("v%0d_SignImmE", k), SignImmE, tbl[k].e_simm);
    end

    // stall: load X, hold for 3 cycles while a write still lands
    drive(ins(6'h23, 5, 7, 16'h1234), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    half1();
    half2();
    for (int c = 0; c < 3; c++) begin
      drive(ins(6'h2B, 9, 9, 16'hAAAA), 32'h0, 32'hA0, 5'd10, 1'b1, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0);
      half1();
      half2();
      chk("stall_A", A, 32'h1234);
      chk("stall_B", B, 32'hDEADBEEF);
      chk("stall_SignImmE", SignImmE, 32'h1234);
      chk("stall_Op", {26'h0, Op}, 32'h23);
      chk("stall_ValidE", {31'h0, ValidE}, 32'h1);
    end
    // stall + flush together: flush wins
    drive(ins(6'h2B, 10, 10, 16'h5555), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1);
    half1();
    half2();
    chk("sf_ValidE", {31'h0, ValidE}, 32'h0);
    chk("sf_A", A, 32'h0);
    chk("sf_SignImmE", SignImmE, 32'h0);
    chk("sf_Op", {26'h0, Op}, 32'h0);
    // write performed during stall is visible
    drive(ins(6'h08, 10, 0, 16'h0), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    half1();
    half2();
    chk("stallwr_A", A, 32'hA0);

    // reset during a writeback discards the write
    rst_n = 1'b0;
    drive(ins(6'h08, 0, 0, 16'h0), 32'h0, 32'h33, 5'd3, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    half1();
    half2();
    rst_n = 1'b1;
    drive(ins(6'h08, 3, 5, 16'h0), 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    half1();
    half2();
    chk("rstwr_A", A, 32'h0);
    chk("rstwr_B", B, 32'h0);

    // randomized stimulus against the model
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[31:26] = 6'(12 + $urandom_range(0, 2));
      WriteRegW = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r[25:21] = WriteRegW;
      if ($urandom_range(0, 3) == 0) r[20:16] = r[25:21];
      InstrD = r;
      PCPlus4D = $urandom;
      ResultW = ($urandom_range(0, 3) == 0) ? 32'h77 : $urandom;
      ALUOutM = ($urandom_range(0, 3) == 0) ? 32'h77 : $urandom;
      RegWriteW = 1'($urandom_range(0, 1));
      ForwardAD = 2'($urandom_range(0, 3));
      ForwardBD = 2'($urandom_range(0, 3));
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      half1();
      half2();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised instruction-decode stage for the 5-stage MIPS pipeline. It contains the register file, the forwarding muxes, the branch comparator and the branch-target adder. It also contains the ID/EX pipeline register, which now carries a valid bit, a stall (hold) input and a flush (bubble) input. It sits between IF/ID and EX, and the hazard unit drives its forwarding, stall and flush controls.

Parameters:
DATA_W, 32, datapath width of registers, operands, PC and immediates.
ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W.
IMM_W, 16, immediate field width taken from InstrD[IMM_W-1:0]; must be ≤ DATA_W.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
InstrD  in  32  instruction in ID.
PCPlus4D  in  DATA_W  PC+4 of the ID instruction.
ResultW  in  DATA_W  writeback data.
WriteRegW  in  ADDR_W  writeback register index.
RegWriteW  in  1  writeback enable.
ALUOutM  in  DATA_W  MEM-stage ALU result, used for forwarding.
ForwardAD  in  2  Rs operand select: 00 regfile, 01 ALUOutM, 10 ResultW, 11 regfile.
ForwardBD  in  2  Rt operand select, same encoding as ForwardAD.
StallE  in  1  hold the ID/EX register.
FlushE  in  1  insert a bubble into ID/EX.
RsD  out  ADDR_W  InstrD[25:21] (truncated/zero-padded to ADDR_W).
RtD  out  ADDR_W  InstrD[20:16].
EqualD  out  1  forwarded Rs operand == forwarded Rt operand.
PCBranchD  out  DATA_W  branch target.
A, B  out  DATA_W  registered forwarded operands.
SignImmE  out  DATA_W  registered extended immediate.
Op, Funct  out  6  registered InstrD[31:26], InstrD[5:0].
RsE, RtE, RdE  out  ADDR_W  registered register indices; RdD = InstrD[15:11].
ValidE  out  1  ID/EX holds a real instruction.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset rst_n.
- Register file reads:
  - Two read ports, combinational, same-cycle (the earlier design had registered reads; this is removed).
  - Register 0 always reads 0.
- Register file writes:
  - Write on the clk edge when RegWriteW=1 and WriteRegW≠0; writes to register 0 are ignored.
- Internal write-through bypass: if RegWriteW=1, WriteRegW≠0 and WriteRegW equals the read index, the read port returns ResultW in the same cycle.
- Forwarding: the forwarded operand (RD1_/RD2_) is selected per ForwardAD/ForwardBD after the bypass.
- EqualD: combinational compare of the forwarded operands.
- Sign extension: SignImmD = InstrD[IMM_W-1:0] sign-extended to DATA_W.
- Branch target: PCBranchD = PCPlus4D + (SignImmD << 2), modulo 2**DATA_W; wrap-around is silent.
- ID/EX register update, priority order per edge:
  1. rst_n=0: ValidE=0 and all ID/EX outputs = 0; all NREGS registers cleared to 0. Reset asserted mid-writeback discards that write.
  2. FlushE=1: ValidE=0 and all ID/EX outputs = 0. Flush beats stall. The register-file write still occurs.
  3. StallE=1: all ID/EX outputs hold their values.
  4. Otherwise: load A, B, SignImmE, Op, Funct, RsE, RtE, RdE from ID; ValidE=1.
- Latency: ID to EX outputs is 1 cycle. Write to read is 0 cycles via the bypass, 1 cycle via the array.
- Register-file writes are independent of StallE and FlushE.

Optional Feature:
Macro ID_ZEXT_LOGIC_EN.
- Defined: when Op is 0x0C (andi), 0x0D (ori) or 0x0E (xori), SignImmD is the zero-extended immediate. PCBranchD still uses the sign-extended immediate.
- Undefined: the immediate is always sign-extended.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then read r1..r31 → all 0; ValidE=0; A=B=0.
- Write, then read: write r5=0x0000_1234, then decode InstrD with Rs=5 → A=0x1234 one cycle later. Same-cycle write r7=0xDEAD_BEEF with Rs=7 → forwarded operand and EqualD use 0xDEADBEEF.
- Zero register: write r0=0xFFFF_FFFF → a read of r0 returns 0. beq r0,r0 → EqualD=1.
- Forwarding and branch: ForwardAD=01 with ALUOutM=0x10, ForwardBD=10 with ResultW=0x10 → EqualD=1. Imm=0xFFFF with PCPlus4D=0x100 → PCBranchD=0xFC.
- Stall and flush: load instruction X, then StallE=1 for 3 cycles → outputs stay at X. Assert StallE=1 and FlushE=1 together → ValidE=0, outputs 0.
- ID_ZEXT_LOGIC_EN: ori with imm 0x8000 → SignImmE=0x0000_8000 when the macro is defined, 0xFFFF_8000 when it is not.
